// File: rtl/seq_detector_param.sv
// seq_detector_param
//
// Serial pattern detector with a registered (Moore-style) match flag.
// Bits are shifted into a PATTERN_LEN-bit history register on every edge
// where in_valid is high. A fill counter tracks how many valid bits the
// history holds, so no match can fire before PATTERN_LEN bits have arrived
// since reset (or since the last match when OVERLAP=0).
//
// Parameters:
//   PATTERN_LEN  number of pattern bits, 2..32
//   PATTERN      pattern value; bit [PATTERN_LEN-1] is received first
//   OVERLAP      1 = keep history after a match, 0 = restart after a match
//   COUNT_W      width of match_count
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, highest priority
//   in           serial data bit
//   in_valid     in is accepted only on edges where this is high
//   clear_count  synchronous clear of match_count (wins over a match)
//   out          high for one cycle after each matching edge
//   match_count  saturating number of detections
//
// Optional feature macro: SEQ_DET_COUNT_EN
//   defined     -> match counter is built
//   not defined -> match_count is tied to 0 and clear_count is ignored

module seq_detector_param #(
    parameter int unsigned               PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0]    PATTERN     = 4'b1010,
    parameter bit                        OVERLAP     = 1'b1,
    parameter int unsigned               COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               clear_count,
    output logic               out,
    output logic [COUNT_W-1:0] match_count
);

    localparam int unsigned FILL_W = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);

    generate
        if (PATTERN_LEN < 2 || PATTERN_LEN > 32) begin : g_bad_len
            initial $error("seq_detector_param: PATTERN_LEN must be 2..32");
        end
    endgenerate

    logic [PATTERN_LEN-1:0] history_q, history_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   out_q, out_d;
    logic                   match;

    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        out_d     = 1'b0;
        match     = 1'b0;
        if (in_valid) begin
            history_d = {history_q[PATTERN_LEN-2:0], in};
            fill_d    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
            // Match is judged on the post-shift state so the flag
            // appears exactly one cycle after the final pattern bit.
            match     = (fill_d == FILL_FULL) && (history_d == PATTERN);
            out_d     = match;
            // Non-overlapping mode only needs the fill reset: old history
            // bits cannot contribute until PATTERN_LEN new bits arrive.
            if (match && !OVERLAP) begin
                fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            history_q <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
        end
    end

    assign out = out_q;

`ifdef SEQ_DET_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_count) begin
            count_d = '0;
        end else if (match && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`else
    // Counter not built; clear_count has nothing to act on.
    logic unused_clear_count;
    assign unused_clear_count = clear_count;
    assign match_count        = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param.
// Three instances share one stimulus stream:
//   dut_a : default (4 bits, 1010, overlap)
//   dut_b : 4 bits, 1010, non-overlapping
//   dut_c : 3 bits, 111, overlap, 2-bit counter (saturation)
// A queue-based model predicts every instance; directed literal checks pin
// the model at the interesting points.

module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_r = 1'b0;
    logic vld = 1'b0;
    logic clr = 1'b0;

    logic       out_a, out_b, out_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .COUNT_W(8)) dut_a (
        .clk(clk), .reset(rst), .in(in_r), .in_valid(vld), .clear_count(clr),
        .out(out_a), .match_count(cnt_a));

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .COUNT_W(8)) dut_b (
        .clk(clk), .reset(rst), .in(in_r), .in_valid(vld), .clear_count(clr),
        .out(out_b), .match_count(cnt_b));

    seq_detector_param #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1), .COUNT_W(2)) dut_c (
        .clk(clk), .reset(rst), .in(in_r), .in_valid(vld), .clear_count(clr),
        .out(out_c), .match_count(cnt_c));

    // ---------------- model ----------------
    int LEN  [3] = '{4, 4, 3};
    int PAT  [3] = '{10, 10, 7};
    bit OVL  [3] = '{1'b1, 1'b0, 1'b1};
    int CMAX [3] = '{255, 255, 3};

    bit hq [3][$];
    bit exp_out [3];
    int exp_cnt [3];

    always @(posedge clk) begin
        bit m;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                hq[k].delete();
                exp_out[k] = 1'b0;
                exp_cnt[k] = 0;
            end else begin
                m = 1'b0;
                if (vld) begin
                    hq[k].push_back(in_r);
                    if (hq[k].size() > LEN[k]) void'(hq[k].pop_front());
                    if (hq[k].size() == LEN[k]) begin
                        m = 1'b1;
                        // oldest bit in the queue must equal the pattern MSB
                        for (int i = 0; i < LEN[k]; i++)
                            if (hq[k][i] != PAT[k][LEN[k]-1-i]) m = 1'b0;
                    end
                    if (m && !OVL[k]) hq[k].delete();
                end
                exp_out[k] = m;
                if (CEN) begin
                    if (clr) exp_cnt[k] = 0;
                    else if (m && exp_cnt[k] < CMAX[k]) exp_cnt[k] = exp_cnt[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_out(input int k);
        return (k == 0) ? int'(out_a) : (k == 1) ? int'(out_b) : int'(out_c);
    endfunction

    function automatic int dut_cnt(input int k);
        return (k == 0) ? int'(cnt_a) : (k == 1) ? int'(cnt_b) : int'(cnt_c);
    endfunction

    // continuous compare against the model
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_out[%0d]", k), dut_out(k), int'(exp_out[k]));
                chk($sformatf("model_cnt[%0d]", k), dut_cnt(k), exp_cnt[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic int ec(input int n);
        return CEN ? n : 0;
    endfunction

    task automatic send(input bit b);
        in_r = b;
        vld  = 1'b1;
        @(negedge clk);
        $display("bit=%0b a:out=%0b cnt=%0d b:out=%0b cnt=%0d c:out=%0b cnt=%0d",
                 b, out_a, cnt_a, out_b, cnt_b, out_c, cnt_c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            vld  = 1'b0;
            in_r = ~in_r;
            @(negedge clk);
            chk("stall_out_a", int'(out_a), 0);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        vld = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            started = 1'b1;
        end
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset, then 1010
        do_reset(2);
        chk("reset_out_a", int'(out_a), 0);
        chk("reset_cnt_a", int'(cnt_a), 0);
        send(1); send(0); send(1);
        chk("early_out_a", int'(out_a), 0);
        send(0);
        chk("first_match_a", int'(out_a), 1);
        chk("first_match_b", int'(out_b), 1);
        chk("first_cnt_a", int'(cnt_a), ec(1));
        // 2: overlap vs non-overlap on 1,0 more
        send(1);
        chk("pulse_end_a", int'(out_a), 0);
        send(0);
        chk("overlap_match_a", int'(out_a), 1);
        chk("no_overlap_b", int'(out_b), 0);
        chk("overlap_cnt_a", int'(cnt_a), ec(2));
        chk("no_overlap_cnt_b", int'(cnt_b), ec(1));

        // 3: stalls in the middle of a pattern
        do_reset(1);
        send(1); send(0);
        idle(3);
        send(1);
        chk("stall_pre_a", int'(out_a), 0);
        send(0);
        chk("stall_match_a", int'(out_a), 1);

        // 4: reset mid-pattern discards history
        do_reset(1);
        send(1); send(0); send(1);
        do_reset(1);
        send(0);
        chk("post_reset_a", int'(out_a), 0);
        send(1); send(0); send(1); send(0);
        chk("post_reset_match_a", int'(out_a), 1);

        // 5: 111 overlap, saturation, clear beating a match
        do_reset(1);
        send(1); send(1);
        chk("c_early", int'(out_c), 0);
        send(1);
        chk("c_bit3", int'(out_c), 1);
        chk("c_cnt3", int'(cnt_c), ec(1));
        send(1);
        chk("c_bit4", int'(out_c), 1);
        send(1);
        chk("c_bit5", int'(out_c), 1);
        chk("c_cnt5", int'(cnt_c), ec(3));
        send(1);
        chk("c_sat", int'(cnt_c), ec(3));
        clr = 1'b1;
        send(1);
        clr = 1'b0;
        chk("c_clr_out", int'(out_c), 1);
        chk("c_clr_cnt", int'(cnt_c), 0);
        vld = 1'b0;
        @(negedge clk);
        chk("c_idle_out", int'(out_c), 0);

        // 6: random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            vld  = ($urandom_range(0, 3) != 0);
            in_r = $urandom_range(0, 1);
            @(negedge clk);
        end
        rst = 1'b0; clr = 1'b0; vld = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
